// File: rtl/ocx_tlx_rcv_crd_sched_pkg.sv
// Shared types and constants for the TLX receive-credit return scheduler.
package ocx_tlx_crd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REQ
  } crd_state_t;

  localparam int unsigned VC_FW   = 4;
  localparam int unsigned DCP_FW  = 6;
  localparam int unsigned VC_MAX  = 15;
  localparam int unsigned DCP_MAX = 63;

endpackage

// File: rtl/ocx_tlx_rcv_crd_sched_if.sv
// Credit release / return handshake bundle between the receive FIFOs,
// the credit scheduler and the transmitter.
interface ocx_tlx_rcv_crd_sched_if;
  import ocx_tlx_crd_pkg::*;

  logic              dlx_tlx_link_up;
  logic              crd_vc0_rel;
  logic              crd_vc1_rel;
  logic              crd_dcp0_rel;
  logic              crd_dcp1_rel;
  logic              crd_cfg_dcp1_rel;
  logic              crd_flush;
  logic              xmt_rcv_crd_ack;
  logic              rcv_xmt_crd_req;
  logic [VC_FW-1:0]  rcv_xmt_crd_vc0;
  logic [VC_FW-1:0]  rcv_xmt_crd_vc1;
  logic [DCP_FW-1:0] rcv_xmt_crd_dcp0;
  logic [DCP_FW-1:0] rcv_xmt_crd_dcp1;
  logic              rcv_crd_ovfl_err;

  modport slave (
    input  dlx_tlx_link_up, crd_vc0_rel, crd_vc1_rel, crd_dcp0_rel, crd_dcp1_rel,
           crd_cfg_dcp1_rel, crd_flush, xmt_rcv_crd_ack,
    output rcv_xmt_crd_req, rcv_xmt_crd_vc0, rcv_xmt_crd_vc1, rcv_xmt_crd_dcp0,
           rcv_xmt_crd_dcp1, rcv_crd_ovfl_err
  );

  modport master (
    output dlx_tlx_link_up, crd_vc0_rel, crd_vc1_rel, crd_dcp0_rel, crd_dcp1_rel,
           crd_cfg_dcp1_rel, crd_flush, xmt_rcv_crd_ack,
    input  rcv_xmt_crd_req, rcv_xmt_crd_vc0, rcv_xmt_crd_vc1, rcv_xmt_crd_dcp0,
           rcv_xmt_crd_dcp1, rcv_crd_ovfl_err
  );

endinterface

// File: rtl/ocx_tlx_rcv_crd_sched_accum.sv
// One saturating credit accumulator: adds 0..2 releases per cycle, removes
// the returned snapshot on ack, and clears while the link is down.
module ocx_tlx_crd_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       inc,
  input  logic             sub_en,
  input  logic [CNT_W-1:0] sub_val,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat
);

  logic [CNT_W:0] sum;

  // Next balance; the snapshot never exceeds the balance, so only the add can overflow.
  always_comb begin
    sum     = {1'b0, cnt - (sub_en ? sub_val : '0)} + (CNT_W+1)'(inc);
    sat     = sum[CNT_W];
    cnt_nxt = sat ? '1 : sum[CNT_W-1:0];
  end

  // Balance register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ocx_tlx_rcv_crd_sched.sv
// Receive-credit return scheduler: accumulates released credits per class
// and hands them to the transmitter in batches, one return per ack.
module ocx_tlx_rcv_crd_sched
  import ocx_tlx_crd_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                   tlx_clk,
  input  logic                   reset,
  ocx_tlx_rcv_crd_sched_if.slave bus
);

  localparam int unsigned EW = (CNT_W > DCP_FW) ? CNT_W : DCP_FW;

  crd_state_t        state;
  logic [7:0]        timer;
  logic              link;
  logic              ack_take;
  logic [1:0]        inc     [4];
  logic [CNT_W-1:0]  sub     [4];
  logic [CNT_W-1:0]  acc     [4];
  logic [CNT_W-1:0]  acc_nxt [4];
  logic [EW-1:0]     acc_ext [4];
  logic [3:0]        sat;
  logic              any_rel;
  logic              any_left;
  logic              trigger;
  logic [VC_FW-1:0]  min_vc0, min_vc1;
  logic [DCP_FW-1:0] min_dcp0, min_dcp1;

  assign link     = bus.dlx_tlx_link_up;
  assign ack_take = bus.rcv_xmt_crd_req & bus.xmt_rcv_crd_ack;

  for (genvar g = 0; g < 4; g++) begin : g_acc
    ocx_tlx_crd_accum #(.CNT_W(CNT_W)) u_accum (
      .clk     (tlx_clk),
      .rst     (reset),
      .clr     (!link),
      .inc     (inc[g]),
      .sub_en  (ack_take),
      .sub_val (sub[g]),
      .cnt     (acc[g]),
      .cnt_nxt (acc_nxt[g]),
      .sat     (sat[g])
    );
  end

  // Release gating, snapshot subtract values, return triggers and clipped field values.
  always_comb begin
    inc[0] = link ? {1'b0, bus.crd_vc0_rel}  : '0;
    inc[1] = link ? {1'b0, bus.crd_vc1_rel}  : '0;
    inc[2] = link ? {1'b0, bus.crd_dcp0_rel} : '0;
    inc[3] = link ? ({1'b0, bus.crd_dcp1_rel} + {1'b0, bus.crd_cfg_dcp1_rel}) : '0;
    sub[0] = CNT_W'(EW'(bus.rcv_xmt_crd_vc0));
    sub[1] = CNT_W'(EW'(bus.rcv_xmt_crd_vc1));
    sub[2] = CNT_W'(EW'(bus.rcv_xmt_crd_dcp0));
    sub[3] = CNT_W'(EW'(bus.rcv_xmt_crd_dcp1));
    for (int unsigned i = 0; i < 4; i++) acc_ext[i] = EW'(acc[i]);
    any_rel  = (inc[0] | inc[1] | inc[2] | inc[3]) != 2'd0;
    any_left = (|acc_nxt[0]) | (|acc_nxt[1]) | (|acc_nxt[2]) | (|acc_nxt[3]);
    trigger  = (timer == 8'(HOLD_CYC - 1))
             | (acc_ext[0] >= EW'(VC_MAX))  | (acc_ext[1] >= EW'(VC_MAX))
             | (acc_ext[2] >= EW'(DCP_MAX)) | (acc_ext[3] >= EW'(DCP_MAX))
             | bus.crd_flush;
    min_vc0  = (acc_ext[0] >= EW'(VC_MAX))  ? VC_FW'(VC_MAX)   : acc_ext[0][VC_FW-1:0];
    min_vc1  = (acc_ext[1] >= EW'(VC_MAX))  ? VC_FW'(VC_MAX)   : acc_ext[1][VC_FW-1:0];
    min_dcp0 = (acc_ext[2] >= EW'(DCP_MAX)) ? DCP_FW'(DCP_MAX) : acc_ext[2][DCP_FW-1:0];
    min_dcp1 = (acc_ext[3] >= EW'(DCP_MAX)) ? DCP_FW'(DCP_MAX) : acc_ext[3][DCP_FW-1:0];
  end

  // Return FSM with hold timer; request and fields are the registered snapshot.
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset || !link) begin
      state                <= IDLE;
      timer                <= '0;
      bus.rcv_xmt_crd_req  <= 1'b0;
      bus.rcv_xmt_crd_vc0  <= '0;
      bus.rcv_xmt_crd_vc1  <= '0;
      bus.rcv_xmt_crd_dcp0 <= '0;
      bus.rcv_xmt_crd_dcp1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_rel) begin
            state <= ACCUM;
            timer <= '0;
          end
        end
        ACCUM: begin
          if (trigger) begin
            state                <= REQ;
            bus.rcv_xmt_crd_req  <= 1'b1;
            bus.rcv_xmt_crd_vc0  <= min_vc0;
            bus.rcv_xmt_crd_vc1  <= min_vc1;
            bus.rcv_xmt_crd_dcp0 <= min_dcp0;
            bus.rcv_xmt_crd_dcp1 <= min_dcp1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        REQ: begin
          if (bus.xmt_rcv_crd_ack) begin
            state                <= any_left ? ACCUM : IDLE;
            timer                <= '0;
            bus.rcv_xmt_crd_req  <= 1'b0;
            bus.rcv_xmt_crd_vc0  <= '0;
            bus.rcv_xmt_crd_vc1  <= '0;
            bus.rcv_xmt_crd_dcp0 <= '0;
            bus.rcv_xmt_crd_dcp1 <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset)     bus.rcv_crd_ovfl_err <= 1'b0;
    else if (|sat) bus.rcv_crd_ovfl_err <= 1'b1;
  end

endmodule

// File: doc/ocx_tlx_rcv_crd_sched.md
OCX_TLX_RCV_CRD_SCHED -- requirements
Module: ocx_tlx_rcv_crd_sched

Interface
REQ-001 Parameter HOLD_CYC, default 16: cycles a non-zero credit balance is held in ACCUM before a return request is forced; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of each internal credit accumulator.
REQ-003 tlx_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 dlx_tlx_link_up  in  1  link status; low means flush all balances.
REQ-006 crd_vc0_rel, crd_vc1_rel, crd_dcp0_rel, crd_dcp1_rel  in  1 each  single-cycle pulses, one credit released per pulse by the receive FIFOs.
REQ-007 crd_cfg_dcp1_rel  in  1  config data-credit release pulse, counted into the dcp1 class.
REQ-008 crd_flush  in  1  pulse requesting immediate return of any non-zero balance.
REQ-009 xmt_rcv_crd_ack  in  1  transmitter accepted the current return; meaningful only while rcv_xmt_crd_req=1.
REQ-010 rcv_xmt_crd_req  out  1  return request.
REQ-011 rcv_xmt_crd_vc0, rcv_xmt_crd_vc1  out  4 each  credit fields.
REQ-012 rcv_xmt_crd_dcp0, rcv_xmt_crd_dcp1  out  6 each  credit fields.
REQ-013 rcv_crd_ovfl_err  out  1  sticky accumulator-overflow error.

Function
REQ-014 Each of the four classes (vc0, vc1, dcp0, dcp1) SHALL keep a CNT_W-bit accumulator; per cycle it gains the sum of that class's release pulses (dcp1 gains 0..2).
REQ-015 The FSM SHALL have exactly three states, IDLE, ACCUM and REQ, reset to IDLE.
REQ-016 IDLE->ACCUM when any release pulse is seen; the hold timer is cleared on entry.
REQ-017 In ACCUM the hold timer increments every cycle.
REQ-018 ACCUM->REQ on the first cycle any of these holds: timer = HOLD_CYC-1; vc accumulator >= 15; dcp accumulator >= 63; crd_flush=1.
REQ-019 On the ACCUM->REQ edge, the output fields SHALL be loaded with min(accumulator, field max), where field max is 15 for vc and 63 for dcp.
REQ-020 rcv_xmt_crd_req SHALL be registered; it rises the cycle after the triggering condition.
REQ-021 While in REQ, rcv_xmt_crd_req and all fields SHALL stay stable until ack.
REQ-022 On ack, each accumulator becomes accumulator minus snapshot plus same-cycle releases; a release coincident with ack is never lost.
REQ-023 After ack the FSM goes REQ->ACCUM with the timer cleared if any updated accumulator is non-zero, otherwise REQ->IDLE.
REQ-024 After ack, rcv_xmt_crd_req deasserts and the fields zero the following cycle; one return is sent per ack.
REQ-025 A ack while rcv_xmt_crd_req=0 SHALL be ignored.
REQ-026 Releases arriving in REQ accumulate but do not alter the held fields.
REQ-027 An accumulator that would exceed 2^CNT_W-1 SHALL saturate and set rcv_crd_ovfl_err, which clears only on reset.
REQ-028 While dlx_tlx_link_up=0, all accumulators, the timer, req and fields SHALL clear, the FSM SHALL enter IDLE, and releases SHALL be ignored; this overrides a pending ack.
REQ-029 Minimum latency from a release pulse to rcv_xmt_crd_req with HOLD_CYC=1 SHALL be 2 cycles.

Reset
REQ-030 Reset SHALL asynchronously force state IDLE, all accumulators and the timer to 0, rcv_xmt_crd_req=0, all fields=0 and rcv_crd_ovfl_err=0.
REQ-031 Reset asserted mid-REQ SHALL drop req without an ack; credits then pending are discarded.

Structure
REQ-032 Package ocx_tlx_crd_pkg SHALL hold the FSM state enum, the field widths (4, 6) and the field maxima (15, 63).
REQ-033 A sub-module ocx_tlx_crd_accum SHALL implement one saturating accumulator with increment, ack-subtract and clear, instantiated four times.
REQ-034 The FSM, hold timer and snapshot registers SHALL reside in the top module.

Verification
REQ-035 HOLD_CYC=16: 3 vc0 pulses at cycles 0-2 -> req rises at cycle 17 with vc0=3 and the other fields 0; ack -> IDLE.
REQ-036 20 consecutive vc1 pulses -> req rises once the accumulator reaches 15 with vc1=15; ack coincident with a pulse -> residual is correct and the FSM re-enters ACCUM.
REQ-037 crd_dcp1_rel and crd_cfg_dcp1_rel pulsed together 40 times -> dcp1 field = 63 and residual = 17 after ack.
REQ-038 Stuck ack=1 while idle -> no req and no counter change; req held 10 cycles without ack -> fields stable throughout.
REQ-039 link_up dropped while in REQ with pending releases -> next cycle req=0, fields 0, IDLE; pulses during link-down are not counted.
REQ-040 CNT_W=4 with 20 dcp0 pulses and ack withheld -> accumulator saturates at 15 and rcv_crd_ovfl_err=1 until reset.
